// File: rtl/guess_round_sequencer_if.sv
// Guess handshakes from the two players into the round sequencer.
// The player side drives Valid/Num and the sequencer side drives Ready.
interface guess_round_sequencer_if #(
    parameter int unsigned N = 32
);
    logic         P1_Valid;
    logic         P1_Ready;
    logic [N-1:0] P1_Num;
    logic         P2_Valid;
    logic         P2_Ready;
    logic [N-1:0] P2_Num;

    modport master (
        output P1_Valid, P1_Num, P2_Valid, P2_Num,
        input  P1_Ready, P2_Ready
    );

    modport slave (
        input  P1_Valid, P1_Num, P2_Valid, P2_Num,
        output P1_Ready, P2_Ready
    );
endinterface

// File: rtl/guess_round_sequencer.sv
// Two-player target-guessing round controller: collects one guess per player per round,
// scores each round by bit agreement with the target, and ends on a hit or after MAX_ROUNDS.
module guess_round_sequencer #(
    parameter int unsigned N          = 32,
    parameter int unsigned MAX_ROUNDS = 10
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     Start,
    input  logic [N-1:0]             Target_Num,
    guess_round_sequencer_if.slave   players,
    output logic                     Busy,
    output logic                     Done,
    output logic [1:0]               Result,
    output logic [3:0]               Round,
    output logic [N+2:0]             Score_1,
    output logic [N+2:0]             Score_2
);
    typedef enum logic [1:0] {ST_IDLE, ST_COLLECT, ST_EVAL, ST_DONE} state_e;

    localparam logic [3:0] LAST_ROUND = 4'(MAX_ROUNDS - 1);

    state_e       state_q, state_d;
    logic [N-1:0] target_q, target_d;
    logic [N-1:0] g1_q, g1_d, g2_q, g2_d;
    logic         got1_q, got1_d, got2_q, got2_d;
    logic [N+2:0] score1_q, score1_d, score2_q, score2_d;
    logic [3:0]   round_q, round_d;
    logic [1:0]   result_q, result_d;

    logic [N+2:0] c1, c2, s1_new, s2_new;
    logic         hit1, hit2;

    function automatic logic [N+2:0] agree_count(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N+2:0] cnt;
        cnt = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cnt = cnt + {{(N+2){1'b0}}, ~(a[i] ^ b[i])};
        end
        return cnt;
    endfunction

    assign c1     = agree_count(g1_q, target_q);
    assign c2     = agree_count(g2_q, target_q);
    assign s1_new = score1_q + c1;
    assign s2_new = score2_q + c2;
    assign hit1   = (g1_q == target_q);
    assign hit2   = (g2_q == target_q);

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        g1_d     = g1_q;
        g2_d     = g2_q;
        got1_d   = got1_q;
        got2_d   = got2_q;
        score1_d = score1_q;
        score2_d = score2_q;
        round_d  = round_q;
        result_d = result_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (Start) begin
                    target_d = Target_Num;
                    score1_d = '0;
                    score2_d = '0;
                    round_d  = '0;
                    result_d = '0;
                    got1_d   = 1'b0;
                    got2_d   = 1'b0;
                    state_d  = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (players.P1_Valid && !got1_q) begin
                    g1_d   = players.P1_Num;
                    got1_d = 1'b1;
                end
                if (players.P2_Valid && !got2_q) begin
                    g2_d   = players.P2_Num;
                    got2_d = 1'b1;
                end
                // Leave on the capturing edge so EVAL follows the last capture directly.
                if (got1_d && got2_d) begin
                    state_d = ST_EVAL;
                end
            end
            ST_EVAL: begin
                score1_d = s1_new;
                score2_d = s2_new;
                if (hit1 || hit2) begin
                    result_d = {hit2, hit1};
                    state_d  = ST_DONE;
                end else if (round_q == LAST_ROUND) begin
                    result_d = {s2_new >= s1_new, s1_new >= s2_new};
                    state_d  = ST_DONE;
                end else begin
                    round_d = round_q + 4'd1;
                    got1_d  = 1'b0;
                    got2_d  = 1'b0;
                    state_d = ST_COLLECT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            target_q <= '0;
            g1_q     <= '0;
            g2_q     <= '0;
            got1_q   <= 1'b0;
            got2_q   <= 1'b0;
            score1_q <= '0;
            score2_q <= '0;
            round_q  <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            g1_q     <= g1_d;
            g2_q     <= g2_d;
            got1_q   <= got1_d;
            got2_q   <= got2_d;
            score1_q <= score1_d;
            score2_q <= score2_d;
            round_q  <= round_d;
            result_q <= result_d;
        end
    end

    assign players.P1_Ready = (state_q == ST_COLLECT) && !got1_q;
    assign players.P2_Ready = (state_q == ST_COLLECT) && !got2_q;
    assign Busy    = (state_q == ST_COLLECT) || (state_q == ST_EVAL);
    assign Done    = (state_q == ST_DONE);
    assign Result  = result_q;
    assign Round   = round_q;
    assign Score_1 = score1_q;
    assign Score_2 = score2_q;
endmodule
